// File: rtl/img_pkt_pkg.sv
// img_pkt_pkg: constants and types shared by the image packet blocks.
// - Default packet geometry: IMG_WORDS_DEF image words, then TRAILER_WORDS_DEF trailer words.
// - Trailer word indices:
//   - PAR_IDX is the XOR parity word.
//   - INFO_IDX carries the frame type in bits [FTYPE_MSB:FTYPE_LSB].
// - state_t is the depacketizer FSM encoding.
//   It is also exported on the debug port.
package img_pkt_pkg;

  localparam int IMG_WORDS_DEF     = 262144;  // 1024x1024 bytes / 4
  localparam int TRAILER_WORDS_DEF = 256;

  localparam int PAR_IDX   = 0;
  localparam int INFO_IDX  = 4;
  localparam int FTYPE_LSB = 8;
  localparam int FTYPE_MSB = 9;
  localparam int FTYPE_W   = FTYPE_MSB - FTYPE_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_TRAILER = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Bits needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/img_unpack_obuf.sv
// img_unpack_obuf: 2-entry output buffer between the FIFO read path and the image stream.
//
// Ports:
// - clk, rst_n: clock and synchronous active-low reset.
// - push, push_data: write one word.
//   The producer only pushes when it holds a credit, so a push never meets a full buffer
//   unless a pop happens in the same cycle.
// - m_data, m_valid, m_ready: output stream.
// - cnt: number of words currently held (0..2).
//   The producer uses it to compute read credits.
//
// Handshake:
// - A word transfers on every rising clk edge where m_valid && m_ready.
// - m_valid never depends on m_ready.
// - Once m_valid is high, m_valid and m_data hold until the transfer happens.
module img_unpack_obuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            cnt
);

  // m_data is the head entry; d1 is the second entry.
  logic [DATA_WIDTH-1:0] d1;
  logic                  pop;

  assign m_valid = (cnt != 2'd0);
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      m_data <= '0;
      d1     <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt != 2'd2) begin
            if (cnt == 2'd0) m_data <= push_data;
            else             d1     <= push_data;
            cnt <= cnt + 2'd1;
          end
        end
        2'b01: begin
          m_data <= d1;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged.
          // With one entry the new word goes straight to the head.
          if (cnt == 2'd1) begin
            m_data <= push_data;
          end else begin
            m_data <= d1;
            d1     <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/img_unpack.sv
// img_unpack: image packet depacketizer on the read side of the image FIFO.
//
// Behaviour:
// - Reads IMG_WORDS image words and streams them on m_data/m_valid/m_ready,
//   XOR-accumulating them as they arrive.
// - Then reads TRAILER_WORDS trailer words, which are checked and dropped.
// - Ends the packet with a one-cycle frame_done pulse carrying the frame type and error status.
//
// Ports:
// - clk, rst_n: clock and synchronous active-low reset.
// - enable: starts a packet when the block is idle.
// - FIFO side: fifo_rden (read strobe), fifo_rddata (valid the cycle after a read), fifo_empty.
// - Stream: m_data, m_valid, m_ready.
//   - A word transfers on a rising edge with m_valid && m_ready.
//   - m_valid/m_data hold while m_ready is low.
// - Status:
//   - frame_done: 1-cycle pulse.
//   - frame_type, parity_err, fmt_err: hold between pulses.
//   - busy: packet in progress.
// - state_dbg: current FSM state.
module img_unpack
  import img_pkt_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int IMG_WORDS     = IMG_WORDS_DEF,
  parameter int TRAILER_WORDS = TRAILER_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_rden,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  frame_done,
  output logic [1:0]            frame_type,
  output logic                  parity_err,
  output logic                  fmt_err,
  output logic                  busy,
  output state_t                state_dbg
);

  localparam int CW = cnt_width(IMG_WORDS);
  localparam int TW = cnt_width(TRAILER_WORDS);

  localparam logic [CW-1:0] IMG_WORDS_C = CW'(IMG_WORDS);
  localparam logic [CW-1:0] IMG_LAST    = CW'(IMG_WORDS - 1);
  localparam logic [TW-1:0] TR_WORDS_C  = TW'(TRAILER_WORDS);
  localparam logic [TW-1:0] TR_LAST     = TW'(TRAILER_WORDS - 1);
  localparam logic [TW-1:0] PAR_IDX_C   = TW'(PAR_IDX);
  localparam logic [TW-1:0] INFO_IDX_C  = TW'(INFO_IDX);

  // Bits of the info word that may legally be nonzero.
  localparam logic [DATA_WIDTH-1:0] FTYPE_MASK =
    DATA_WIDTH'((1 << FTYPE_W) - 1) << FTYPE_LSB;

  state_t                state;
  logic [CW-1:0]         rd_cnt;      // image reads issued
  logic [TW-1:0]         tr_rd_cnt;   // trailer reads issued
  logic [TW-1:0]         tr_rx_cnt;   // trailer words received
  logic                  rd_valid_q;  // fifo_rddata carries a word this cycle
  logic                  rd_img_q;    // ...and that word is an image word
  logic [DATA_WIDTH-1:0] acc;
  logic [1:0]            ftype_n;
  logic                  par_err_n;
  logic                  fmt_err_n;

  logic [1:0]            obuf_cnt;
  logic                  pop;
  logic                  img_rx;
  logic                  tr_rx;
  logic                  credit_ok;
  logic [2:0]            occupancy;

  assign state_dbg = state;
  assign pop       = m_valid && m_ready;
  assign img_rx    = rd_valid_q && rd_img_q;
  assign tr_rx     = rd_valid_q && !rd_img_q;

  // A read is allowed only if its word will find a free buffer slot.
  // Count what the buffer will hold once the in-flight image word lands
  // and the word leaving this cycle (pop) is gone.
  assign occupancy = {1'b0, obuf_cnt} + {2'b00, img_rx};
  assign credit_ok = occupancy < (3'd2 + {2'b00, pop});

  always_comb begin
    fifo_rden = 1'b0;
    case (state)
      ST_DATA:             fifo_rden = !fifo_empty && (rd_cnt < IMG_WORDS_C) && credit_ok;
      ST_TRAILER, ST_DONE: fifo_rden = !fifo_empty && (tr_rd_cnt < TR_WORDS_C);
      default:             fifo_rden = 1'b0;
    endcase
    // Keep the strobe quiet while reset is held, before the state is known.
    if (!rst_n) fifo_rden = 1'b0;
  end

  img_unpack_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (img_rx),
    .push_data (fifo_rddata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .cnt       (obuf_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rd_cnt     <= '0;
      tr_rd_cnt  <= '0;
      tr_rx_cnt  <= '0;
      rd_valid_q <= 1'b0;
      rd_img_q   <= 1'b0;
      acc        <= '0;
      ftype_n    <= 2'd0;
      par_err_n  <= 1'b0;
      fmt_err_n  <= 1'b0;
      frame_done <= 1'b0;
      frame_type <= 2'd0;
      parity_err <= 1'b0;
      fmt_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rd_valid_q <= fifo_rden;
      rd_img_q   <= fifo_rden && (state == ST_DATA);

      if (img_rx) acc <= acc ^ fifo_rddata;

      if (tr_rx) begin
        tr_rx_cnt <= tr_rx_cnt + TW'(1);
        if (tr_rx_cnt == PAR_IDX_C) begin
          par_err_n <= (fifo_rddata != acc);
        end else if (tr_rx_cnt == INFO_IDX_C) begin
          ftype_n <= fifo_rddata[FTYPE_MSB:FTYPE_LSB];
          if ((fifo_rddata & ~FTYPE_MASK) != '0) fmt_err_n <= 1'b1;
        end else if (fifo_rddata != '0) begin
          fmt_err_n <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (enable) begin
            state     <= ST_DATA;
            busy      <= 1'b1;
            rd_cnt    <= '0;
            tr_rd_cnt <= '0;
            tr_rx_cnt <= '0;
            acc       <= '0;
            ftype_n   <= 2'd0;
            par_err_n <= 1'b0;
            fmt_err_n <= 1'b0;
          end
        end
        ST_DATA: begin
          if (fifo_rden) begin
            rd_cnt <= rd_cnt + CW'(1);
            if (rd_cnt == IMG_LAST) state <= ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          if (fifo_rden) begin
            tr_rd_cnt <= tr_rd_cnt + TW'(1);
            if (tr_rd_cnt == TR_LAST) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Wait for the last trailer word and for the stream to drain.
          // busy stays high through the frame_done cycle and drops in IDLE afterwards.
          if ((tr_rx_cnt == TR_WORDS_C) && !m_valid) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
            frame_type <= ftype_n;
            parity_err <= par_err_n;
            fmt_err    <= fmt_err_n;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_unpack.sv
// Directed bench for img_unpack with 8 image words and 8 trailer words per packet.
module tb_img_unpack;
  import img_pkt_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] fifo_rddata = '0;
  logic          fifo_rden;
  logic          fifo_empty;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          frame_done;
  logic [1:0]    frame_type;
  logic          parity_err;
  logic          fmt_err;
  logic          busy;
  state_t        state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  img_unpack #(
    .DATA_WIDTH    (DW),
    .IMG_WORDS     (8),
    .TRAILER_WORDS (8)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fifo_rddata (fifo_rddata),
    .fifo_rden   (fifo_rden),
    .fifo_empty  (fifo_empty),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .frame_done  (frame_done),
    .frame_type  (frame_type),
    .parity_err  (parity_err),
    .fmt_err     (fmt_err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- FIFO model ----------------
  logic [DW-1:0] fmem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          empty_force;
  logic          fifo_flush;

  assign fifo_empty = empty_force || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rden) begin
      fifo_rddata <= fmem[rd_ptr & 255];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic          stall_q    = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", m_data, stall_data);
      end
      if (m_valid && m_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
      end
      stall_q    = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_pkt(input logic [DW-1:0] t0, input logic [DW-1:0] t4,
                          input logic [DW-1:0] t6);
    logic [DW-1:0] w;
    for (int i = 1; i <= 8; i++) begin
      fmem[wr_ptr & 255] = DW'(i);
      wr_ptr++;
      exp_q.push_back(DW'(i));
    end
    for (int i = 0; i < 8; i++) begin
      w = '0;
      if (i == 0) w = t0;
      if (i == 4) w = t4;
      if (i == 6) w = t6;
      fmem[wr_ptr & 255] = w;
      wr_ptr++;
    end
  endtask

  // rmode 0: m_ready always high.
  // rmode 1: m_ready low for 6 cycles, then toggling.
  task automatic run_pkt(input logic [DW-1:0] t0, input logic [DW-1:0] t4,
                         input logic [DW-1:0] t6, input int rmode, input bit stalls,
                         input bit lat, input int exp_type, input int exp_par,
                         input int exp_fmt, output int done_cyc);
    int  base;
    int  nout;
    int  first_c;
    int  last_c;
    bit  done;
    load_pkt(t0, t4, t6);
    base     = rd_ptr;
    nout     = 0;
    first_c  = 0;
    last_c   = 0;
    done     = 0;
    done_cyc = 0;
    @(posedge clk); #1;
    enable  = 1'b1;
    m_ready = (rmode == 0);
    @(negedge clk);
    if (lat) begin
      check("rden_before_start", 32'(fifo_rden), 32'd0);
      check("busy_before_start", 32'(busy), 32'd0);
    end
    for (int c = 1; c <= 300 && !done; c++) begin
      @(posedge clk); #1;
      enable      = 1'b0;
      m_ready     = (rmode == 0) ? 1'b1 : ((c > 6) && (c % 2 == 0));
      empty_force = stalls && ((c >= 3 && c < 8) || (c >= 16 && c < 21));
      @(negedge clk);
      if (lat && c == 1) begin
        check("first_rden", 32'(fifo_rden), 32'd1);
        check("busy_in_data", 32'(busy), 32'd1);
      end
      if (lat && c == 2) check("no_valid_yet", 32'(m_valid), 32'd0);
      if (lat && c == 3) begin
        check("first_valid", 32'(m_valid), 32'd1);
        check("first_data", m_data, 32'd1);
      end
      if (rmode == 1 && c == 6) check("reads_when_blocked", 32'(rd_ptr - base), 32'd2);
      if (m_valid && m_ready) begin
        if (nout == 0) first_c = c;
        last_c = c;
        nout++;
      end
      if (frame_done) begin
        done     = 1;
        done_cyc = c;
        check("frame_type", 32'(frame_type), 32'(exp_type));
        check("parity_err", 32'(parity_err), 32'(exp_par));
        check("fmt_err", 32'(fmt_err), 32'(exp_fmt));
        check("busy_at_done", 32'(busy), 32'd1);
      end
    end
    if (!done) check("frame_done_seen", 32'd0, 32'd1);
    empty_force = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", 32'(frame_done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("words_out", 32'(nout), 32'd8);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    if (rmode == 0 && !stalls) check("throughput_span", 32'(last_c - first_c), 32'd7);
  endtask

  task automatic reset_mid_pkt;
    int nout;
    load_pkt(32'h8, 32'h200, 32'h0);
    nout = 0;
    @(posedge clk); #1;
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int c = 1; c <= 100 && nout < 4; c++) begin
      @(posedge clk); #1;
      enable = 1'b0;
      @(negedge clk);
      if (m_valid && m_ready) nout++;
    end
    check("mid_words_before_reset", 32'(nout), 32'd4);
    @(posedge clk); #1;
    m_ready    = 1'b0;
    rst_n      = 1'b0;
    fifo_flush = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_rden", 32'(fifo_rden), 32'd0);
    check("rst_ftype", 32'(frame_type), 32'd0);
    check("rst_fmt_err", 32'(fmt_err), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    fifo_flush = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  int clean_done;
  int d;

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    m_ready     = 1'b0;
    empty_force = 1'b0;
    fifo_flush  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rden", 32'(fifo_rden), 32'd0);
    check("reset_valid", 32'(m_valid), 32'd0);
    check("reset_data", m_data, 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_ftype", 32'(frame_type), 32'd0);
    check("reset_par", 32'(parity_err), 32'd0);
    check("reset_fmt", 32'(fmt_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean packet: parity 1^..^8 = 8, type 2.
    run_pkt(32'h8, 32'h200, 32'h0, 0, 1'b0, 1'b1, 2, 0, 0, clean_done);
    // Bad parity word.
    run_pkt(32'h9, 32'h200, 32'h0, 0, 1'b0, 1'b0, 2, 1, 0, d);
    // Reserved bit in the info word, type 3.
    run_pkt(32'h8, 32'h10300, 32'h0, 0, 1'b0, 1'b0, 3, 0, 1, d);
    // Nonzero word 6.
    run_pkt(32'h8, 32'h200, 32'h1, 0, 1'b0, 1'b0, 2, 0, 1, d);
    // Reset after 4 words, then a fresh clean packet.
    reset_mid_pkt();
    run_pkt(32'h8, 32'h200, 32'h0, 0, 1'b0, 1'b0, 2, 0, 0, d);
    // Back-pressure.
    run_pkt(32'h8, 32'h200, 32'h0, 1, 1'b0, 1'b0, 2, 0, 0, d);
    // Empty stalls mid-data and mid-trailer.
    run_pkt(32'h8, 32'h200, 32'h0, 0, 1'b1, 1'b0, 2, 0, 0, d);
    check("stall_delays_done", 32'(d > clean_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/img_unpack.md
# img_unpack

Frame depacketizer on the read side of the image FIFO, the consumer of packets written by the packetizer upstream. It pulls one image packet from the FIFO, streams the image words out on a valid/ready interface, and XOR-accumulates them. It then consumes the fixed trailer, checks the parity word and reserved fields, and reports frame type and error status with a single `frame_done` pulse. It sits between the DDR-side FIFO and the EMMC/NET writers.

## Interface
Parameters:
- `DATA_WIDTH`, 32: FIFO and stream word width.
- `IMG_WORDS`, 262144: image words per packet (1024×1024 bytes / 4).
- `TRAILER_WORDS`, 256: trailer words per packet; must be ≥ 5.

Ports (reset rst_n, synchronous, active-low; clock clk):
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous reset, active low.
- `enable`  in  1  permits the start of a new packet while in IDLE.
- `fifo_rddata`  in  DATA_WIDTH  FIFO read data, valid 1 cycle after `fifo_rden`.
- `fifo_rden`  out  1  FIFO read strobe.
- `fifo_empty`  in  1  FIFO empty.
- `m_data`  out  DATA_WIDTH  image word out.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accept.
- `frame_done`  out  1  one-cycle pulse at packet end.
- `frame_type`  out  2  frame type from trailer word 4, bits [9:8].
- `parity_err`  out  1  trailer word 0 ≠ XOR of image words.
- `fmt_err`  out  1  nonzero reserved trailer bits seen.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Packet format: IMG_WORDS image words, then the trailer.
  - Trailer word 0: XOR of all image words.
  - Words 1–3: zero.
  - Word 4: frame type in [9:8], all other bits zero.
  - Words 5..TRAILER_WORDS-1: zero.
- States:
  - IDLE→DATA when `enable`=1. Clear read/receive counters and the parity accumulator.
  - DATA→TRAILER when the IMG_WORDS-th read has been issued.
  - TRAILER→DONE when the TRAILER_WORDS-th read has been issued.
  - DONE→IDLE when all trailer words are received and `m_valid`=0. The `frame_done` pulse is issued on this transition.
- Read issue in DATA: `fifo_rden` = !`fifo_empty` && reads_issued < IMG_WORDS && (obuf_cnt + inflight − pop) < 2, where pop = `m_valid`&&`m_ready`.
- Read issue in TRAILER/DONE: `fifo_rden` = !`fifo_empty` && trailer reads remaining. Trailer words are never forwarded and never back-pressured by `m_ready`.
- Each received image word:
  - is pushed into the 2-entry output buffer;
  - is XORed into `acc`, DATA_WIDTH bits.
- Each received trailer word, by index:
  - Index 0: `parity_err_n` = (word ≠ acc).
  - Index 4: capture [9:8]; any other bit set → `fmt_err_n`.
  - Other indices: word ≠ 0 → `fmt_err_n`.
- `frame_type`, `parity_err` and `fmt_err` update from the pending values on the `frame_done` cycle and hold until the next `frame_done`.
- Counters are wide enough for IMG_WORDS, i.e. $clog2(IMG_WORDS+1) bits. There is no wrap within a packet.
- `enable` deasserted mid-packet has no effect; the packet completes.
- Reset at any point returns to IDLE and discards buffered and in-flight data. The next packet must start at a packet boundary.

## Timing
- Reset values: `fifo_rden`=0, `m_valid`=0, `m_data`=0, `frame_done`=0, `frame_type`=0, `parity_err`=0, `fmt_err`=0, `busy`=0.
- `fifo_rden` is registered-safe: the read in cycle t yields data in cycle t+1.
- Latency:
  - Earliest `fifo_rden` is 1 cycle after the IDLE→DATA transition.
  - FIFO data to `m_valid` is 1 cycle.
- Throughput: 1 word/cycle with `m_ready`=1 and a non-empty FIFO.
- Stream rules: `m_data` stays stable while `m_valid`=1 && `m_ready`=0. Words are never dropped or duplicated.
- Back-pressure: the buffer holds at most 2 words. With `m_ready` low the block stops reading after the buffer is full; there is no overflow.
- `fifo_empty` mid-packet stalls reads only; state and counters hold.
- `frame_done` is asserted for exactly 1 cycle, in the cycle the status outputs update. `busy` deasserts on the next cycle.

## Structure
- Shared package `img_pkt_pkg`:
  - IMG_WORDS, TRAILER_WORDS defaults;
  - trailer indices PAR_IDX=0, INFO_IDX=4;
  - FTYPE_LSB=8, FTYPE_MSB=9;
  - state encoding IDLE/DATA/TRAILER/DONE.
- One sub-module, `img_unpack_obuf`: 2-entry valid/ready skid/output buffer exposing `cnt` for read-credit calculation.

## Test plan
Override IMG_WORDS=8, TRAILER_WORDS=8 for directed tests.
- **Clean packet:** data 1..8, trailer {0x00000008,0,0,0,0x00000200,0,0,0}, `m_ready`=1 → 8 words out in order at 1/cycle; `frame_done` pulse; `frame_type`=2, `parity_err`=0, `fmt_err`=0.
- **Bad parity:** same packet with word 0 = 0x00000009 → `parity_err`=1, `fmt_err`=0, all 8 data words still output.
- **Reserved bits:** word 4 = 0x00010300 → `frame_type`=3, `fmt_err`=1. Separately, word 6 = 1 → `fmt_err`=1.
- **Back-pressure:** `m_ready` toggles 1/0 every cycle → no loss or duplication; at most 2 words buffered; `m_data` stable while stalled.
- **Empty stalls:** FIFO empty for 5 cycles mid-data and again mid-trailer → output identical to the clean case; `frame_done` is delayed only.
- **Reset mid-packet:** reset after 4 data words, then a fresh clean packet → `busy` drops; the second packet produces correct data and status with no stale parity.
